// File: rtl/dp_types_pkg.sv
// Shared datapath types for the branch predictor: word type, resolution
// status, 2-bit counter encoding and a PC increment helper.
package dp_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Branch resolution status reported to the hazard unit
  typedef enum logic [1:0] {
    BP_NONE    = 2'b00,
    BP_CORRECT = 2'b01,
    BP_MISPRED = 2'b10
  } branch_pred_state_t;

  // 2-bit saturating direction counter
  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt2_t;

  localparam word_t PC_STEP = 32'h0000_0004;

  // Sequential next PC; wraps naturally modulo 2^32
  function automatic word_t pc_plus4(input word_t pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Saturating 2-bit direction counter next-state logic.
module sat_counter2
  import dp_types_pkg::*;
(
  input  cnt2_t cnt,
  input  logic  taken,
  output cnt2_t cnt_next
);

  // Step toward the resolved direction, holding at SNT and ST
  always_comb begin
    cnt_next = cnt;
    case (cnt)
      CNT_SNT: cnt_next = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: cnt_next = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  cnt_next = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  cnt_next = taken ? CNT_ST  : CNT_WT;
      default: cnt_next = CNT_WNT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup,
// MEM-stage resolution status / fix PC, and table update on accepted
// branches. Define BP_STATS_EN to build the performance counters.
module branch_predictor
  import dp_types_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  word_t              if_pc,
  output logic               pred_taken,
  output word_t              pred_target,
  input  logic               upd_en,
  input  logic               mem_branch,
  input  word_t              mem_pc,
  input  logic               mem_taken,
  input  word_t              mem_target,
  input  logic               mem_pred_taken,
  output branch_pred_state_t bp_stat,
  output word_t              fix_pc,
  output logic [31:0]        br_count,
  output logic [31:0]        mis_count
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  // Table storage
  logic             valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  word_t            target_q [BTB_ENTRIES];
  cnt2_t            cnt_q    [BTB_ENTRIES];

  // Fetch-side lookup
  logic [IDX_W-1:0] lk_idx_s;
  logic [TAG_W-1:0] lk_tag_s;
  logic             lk_hit_s;

  assign lk_idx_s = if_pc[IDX_W+1:2];
  assign lk_tag_s = if_pc[WORD_W-1:IDX_W+2];
  assign lk_hit_s = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);

  // Prediction reads the table as it stands; a same-cycle update is not forwarded
  always_comb begin
    pred_taken  = lk_hit_s && cnt_q[lk_idx_s][1];
    pred_target = pc_plus4(if_pc);
    if (pred_taken) begin
      pred_target = target_q[lk_idx_s];
    end else begin
      pred_target = pc_plus4(if_pc);
    end
  end

  // Resolution status and corrected PC for the MEM-stage instruction
  always_comb begin
    bp_stat = BP_NONE;
    fix_pc  = pc_plus4(mem_pc);
    if (!mem_branch) begin
      bp_stat = BP_NONE;
    end else if (mem_pred_taken == mem_taken) begin
      bp_stat = BP_CORRECT;
    end else begin
      bp_stat = BP_MISPRED;
    end
    if (mem_taken) begin
      fix_pc = mem_target;
    end else begin
      fix_pc = pc_plus4(mem_pc);
    end
  end

  // Update-side addressing
  logic [IDX_W-1:0] up_idx_s;
  logic [TAG_W-1:0] up_tag_s;
  logic             up_hit_s;
  logic             up_accept_s;
  cnt2_t            up_cnt_next_s;

  assign up_idx_s    = mem_pc[IDX_W+1:2];
  assign up_tag_s    = mem_pc[WORD_W-1:IDX_W+2];
  assign up_hit_s    = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
  assign up_accept_s = upd_en && mem_branch;

  sat_counter2 u_sat_counter2 (
    .cnt      (cnt_q[up_idx_s]),
    .taken    (mem_taken),
    .cnt_next (up_cnt_next_s)
  );

  // Next contents of the entry addressed by mem_pc
  logic             we_d;
  logic             valid_d;
  logic [TAG_W-1:0] tag_d;
  word_t            target_d;
  cnt2_t            cnt_d;

  // Hit: train counter (and refresh target when taken); miss: allocate only when taken
  always_comb begin
    we_d     = 1'b0;
    valid_d  = valid_q[up_idx_s];
    tag_d    = tag_q[up_idx_s];
    target_d = target_q[up_idx_s];
    cnt_d    = cnt_q[up_idx_s];
    if (up_accept_s) begin
      if (up_hit_s) begin
        we_d  = 1'b1;
        cnt_d = up_cnt_next_s;
        if (mem_taken) begin
          target_d = mem_target;
        end else begin
          target_d = target_q[up_idx_s];
        end
      end else if (mem_taken) begin
        we_d     = 1'b1;
        valid_d  = 1'b1;
        tag_d    = up_tag_s;
        target_d = mem_target;
        cnt_d    = CNT_WT;
      end else begin
        we_d = 1'b0;
      end
    end else begin
      we_d = 1'b0;
    end
  end

  // Table state: reset clears valids and sets counters weakly not-taken
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0000_0000;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (we_d) begin
      valid_q[up_idx_s]  <= valid_d;
      tag_q[up_idx_s]    <= tag_d;
      target_q[up_idx_s] <= target_d;
      cnt_q[up_idx_s]    <= cnt_d;
    end else begin
      valid_q[up_idx_s]  <= valid_q[up_idx_s];
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mis_count_q, mis_count_d;

  // Saturating event counters for accepted updates and mispredicts
  always_comb begin
    br_count_d  = br_count_q;
    mis_count_d = mis_count_q;
    if (up_accept_s) begin
      if (br_count_q != 32'hFFFF_FFFF) begin
        br_count_d = br_count_q + 32'd1;
      end else begin
        br_count_d = br_count_q;
      end
      if ((bp_stat == BP_MISPRED) && (mis_count_q != 32'hFFFF_FFFF)) begin
        mis_count_d = mis_count_q + 32'd1;
      end else begin
        mis_count_d = mis_count_q;
      end
    end else begin
      br_count_d  = br_count_q;
      mis_count_d = mis_count_q;
    end
  end

  // Counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      br_count_q  <= 32'h0000_0000;
      mis_count_q <= 32'h0000_0000;
    end else begin
      br_count_q  <= br_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  assign br_count  = br_count_q;
  assign mis_count = mis_count_q;
`else
  assign br_count  = 32'h0000_0000;
  assign mis_count = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (16 entries).
module tb_branch_predictor;
  import dp_types_pkg::*;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  word_t              if_pc = 32'h0000_0040;
  logic               pred_taken;
  word_t              pred_target;
  logic               upd_en = 1'b0;
  logic               mem_branch = 1'b0;
  word_t              mem_pc = 32'h0;
  logic               mem_taken = 1'b0;
  word_t              mem_target = 32'h0;
  logic               mem_pred_taken = 1'b0;
  branch_pred_state_t bp_stat;
  word_t              fix_pc;
  logic [31:0]        br_count;
  logic [31:0]        mis_count;

  int n_assert = 0;
  int n_fail   = 0;

  branch_predictor #(.BTB_ENTRIES(16)) dut (
    .CLK(CLK), .RST(RST), .if_pc(if_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_en(upd_en), .mem_branch(mem_branch),
    .mem_pc(mem_pc), .mem_taken(mem_taken), .mem_target(mem_target),
    .mem_pred_taken(mem_pred_taken), .bp_stat(bp_stat), .fix_pc(fix_pc),
    .br_count(br_count), .mis_count(mis_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat(input int n);
`ifdef BP_STATS_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_mem(input logic br, input word_t pc, input logic tk,
                         input word_t tgt, input logic pr);
    mem_branch     = br;
    mem_pc         = pc;
    mem_taken      = tk;
    mem_target     = tgt;
    mem_pred_taken = pr;
  endtask

  // One accepted update, checking status and fix PC before the edge
  task automatic upd(input string tag, input word_t pc, input logic tk, input word_t tgt,
                     input logic pr, input logic [31:0] exp_stat, input word_t exp_fix);
    set_mem(1'b1, pc, tk, tgt, pr);
    upd_en = 1'b1;
    #1;
    check({tag, "_stat"}, bp_stat, exp_stat);
    check({tag, "_fix"}, fix_pc, exp_fix);
    tick();
    mem_branch = 1'b0;
    upd_en     = 1'b0;
    #1;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_pred", pred_taken, 1'b0);
    check("rst_target", pred_target, 32'h0000_0044);
    check("rst_br", br_count, 32'd0);
    check("rst_mis", mis_count, 32'd0);
    check("rst_stat", bp_stat, BP_NONE);
    tick();
    RST = 1'b0;
    #1;
    check("post_rst_pred", pred_taken, 1'b0);
    check("post_rst_target", pred_target, 32'h0000_0044);

    // Miss + taken allocates WT; same-cycle lookup sees old contents
    set_mem(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0);
    upd_en = 1'b1;
    #1;
    check("nobypass_pred", pred_taken, 1'b0);
    check("u1_stat", bp_stat, BP_MISPRED);
    check("u1_fix", fix_pc, 32'h0000_0100);
    tick();
    mem_branch = 1'b0;
    upd_en     = 1'b0;
    #1;
    check("alloc_pred", pred_taken, 1'b1);
    check("alloc_target", pred_target, 32'h0000_0100);
    check("u1_br", br_count, stat(1));
    check("u1_mis", mis_count, stat(1));

    // Not-taken training WT -> WNT -> SNT, then hold at SNT
    upd("u2", 32'h0000_0040, 1'b0, 32'h0, 1'b1, BP_MISPRED, 32'h0000_0044);
    check("wnt_pred", pred_taken, 1'b0);
    check("wnt_target", pred_target, 32'h0000_0044);
    upd("u3", 32'h0000_0040, 1'b0, 32'h0, 1'b0, BP_CORRECT, 32'h0000_0044);
    check("snt_pred", pred_taken, 1'b0);
    upd("u4", 32'h0000_0040, 1'b0, 32'h0, 1'b0, BP_CORRECT, 32'h0000_0044);
    check("snt_hold_pred", pred_taken, 1'b0);
    // From SNT one taken step reaches only WNT; a second reaches WT with new target
    upd("u5", 32'h0000_0040, 1'b1, 32'h0000_0104, 1'b0, BP_MISPRED, 32'h0000_0104);
    check("snt_up_pred", pred_taken, 1'b0);
    check("snt_up_target", pred_target, 32'h0000_0044);
    upd("u6", 32'h0000_0040, 1'b1, 32'h0000_0104, 1'b0, BP_MISPRED, 32'h0000_0104);
    check("wt_pred", pred_taken, 1'b1);
    check("wt_target", pred_target, 32'h0000_0104);
    check("u6_br", br_count, stat(6));
    check("u6_mis", mis_count, stat(4));

    // Aliasing: 0x80 shares index 0 with 0x40 but has a different tag
    if_pc = 32'h0000_0080;
    #1;
    check("alias_pred", pred_taken, 1'b0);
    check("alias_target", pred_target, 32'h0000_0084);
    upd("u7", 32'h0000_0080, 1'b0, 32'h0, 1'b0, BP_CORRECT, 32'h0000_0084);
    if_pc = 32'h0000_0040;
    #1;
    check("noalloc_keep_pred", pred_taken, 1'b1);
    // Taken-and-predicted-taken is correct regardless of target
    upd("u8", 32'h0000_0080, 1'b1, 32'h0000_0300, 1'b1, BP_CORRECT, 32'h0000_0300);
    check("evicted_pred", pred_taken, 1'b0);
    if_pc = 32'h0000_0080;
    #1;
    check("realloc_pred", pred_taken, 1'b1);
    check("realloc_target", pred_target, 32'h0000_0300);
    check("u8_br", br_count, stat(8));
    check("u8_mis", mis_count, stat(4));

    upd("u9", 32'h0000_0010, 1'b1, 32'h0000_0200, 1'b0, BP_MISPRED, 32'h0000_0200);
    check("u9_mis", mis_count, stat(5));

    // Stalled MEM stage: no update while upd_en=0, exactly one when released
    if_pc = 32'h0000_0020;
    set_mem(1'b1, 32'h0000_0020, 1'b1, 32'h0000_0240, 1'b0);
    upd_en = 1'b0;
    tick(); tick(); tick();
    check("stall_pred", pred_taken, 1'b0);
    check("stall_br", br_count, stat(9));
    upd_en = 1'b1;
    tick();
    upd_en = 1'b0;
    mem_branch = 1'b0;
    #1;
    check("stall_alloc_pred", pred_taken, 1'b1);
    check("stall_alloc_target", pred_target, 32'h0000_0240);
    check("stall_br1", br_count, stat(10));
    set_mem(1'b1, 32'h0000_0020, 1'b0, 32'h0, 1'b1);
    tick(); tick(); tick();
    check("stall2_pred", pred_taken, 1'b1);
    upd_en = 1'b1;
    tick();
    upd_en = 1'b0;
    mem_branch = 1'b0;
    #1;
    check("stall2_pred_after", pred_taken, 1'b0);
    // Single step left WNT, so one taken returns to WT
    upd("u10", 32'h0000_0020, 1'b1, 32'h0000_0240, 1'b0, BP_MISPRED, 32'h0000_0240);
    check("one_step_pred", pred_taken, 1'b1);
    check("u10_br", br_count, stat(12));
    check("u10_mis", mis_count, stat(8));

    // PC+4 wrap on both paths (no update: upd_en low)
    if_pc = 32'hFFFF_FFFC;
    set_mem(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1);
    #1;
    check("wrap_target", pred_target, 32'h0000_0000);
    check("wrap_fix", fix_pc, 32'h0000_0000);
    check("wrap_stat", bp_stat, BP_MISPRED);
    mem_branch = 1'b0;
    tick();
    check("wrap_br", br_count, stat(12));

    // Reset asserted while an update is pending clears immediately and drops it
    if_pc = 32'h0000_0020;
    set_mem(1'b1, 32'h0000_0060, 1'b1, 32'h0000_0400, 1'b0);
    upd_en = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    check("midrst_pred", pred_taken, 1'b0);
    check("midrst_target", pred_target, 32'h0000_0024);
    check("midrst_br", br_count, 32'd0);
    check("midrst_mis", mis_count, 32'd0);
    tick();
    RST = 1'b0;
    upd_en = 1'b0;
    mem_branch = 1'b0;
    if_pc = 32'h0000_0060;
    #1;
    check("dropped_pred", pred_taken, 1'b0);
    check("dropped_target", pred_target, 32'h0000_0064);
    tick();
    check("dropped_br", br_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BTB_ENTRIES, default 16, power of two from 4 to 64, number of predictor entries.
REQ-002 SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port if_pc, input, word_t, PC of the instruction currently in fetch.
REQ-005 SHALL have port pred_taken, output, 1, fetch-stage prediction for if_pc.
REQ-006 SHALL have port pred_target, output, word_t, predicted next PC: BTB target if taken, else if_pc+4.
REQ-007 SHALL have port upd_en, input, 1, MEM stage advancing (ex_mem_en from the hazard unit); gates all updates.
REQ-008 SHALL have port mem_branch, input, 1, MEM-stage instruction is a conditional branch (BEQ/BNE).
REQ-009 SHALL have the following MEM-stage input ports:
- mem_pc, word_t, PC of the MEM-stage instruction.
- mem_taken, 1, resolved branch outcome.
- mem_target, word_t, resolved branch target.
- mem_pred_taken, 1, prediction piped from fetch.
REQ-010 SHALL have port bp_stat, output, branch_pred_state_t, resolution status; this output drives the hazard unit bp_stat input.
REQ-011 SHALL have port fix_pc, output, word_t, corrected PC on a mispredict: mem_target if taken, else mem_pc+4.
REQ-012 SHALL have ports br_count and mis_count, output, 32 each, performance counters (see Configuration).

Function
REQ-013 SHALL index the table with idx = pc[log2(BTB_ENTRIES)+1:2] and compare tag = the remaining upper PC bits.
- Each entry holds: valid, tag, target (word_t), and a 2-bit counter.
- Counter encoding: SNT=00, WNT=01, WT=10, ST=11.
REQ-014 SHALL drive pred_taken=1 only when the entry is valid, the tag matches, and counter[1]=1; the lookup is combinational, with zero-cycle latency.
REQ-015 SHALL compute bp_stat combinationally:
- BP_NONE when mem_branch=0.
- BP_CORRECT when mem_pred_taken==mem_taken.
- BP_MISPRED when they differ.
REQ-016 SHALL count a mem_pred_taken=1, mem_taken=1 branch as BP_CORRECT even if the BTB target differs from mem_target, because the target comes from the same BTB entry.
REQ-017 SHALL update the table on a rising edge only when upd_en=1 and mem_branch=1.
REQ-018 SHALL apply these rules on a hit (valid and tag match):
- Taken: counter saturating-increments and target is written with mem_target.
- Not taken: counter saturating-decrements.
REQ-019 SHALL apply these rules on a miss:
- Taken: allocate the entry (overwrite); valid=1, tag, target=mem_target, counter=WT.
- Not taken: no allocation.
REQ-020 SHALL give no bypass when the update and lookup hit the same index in the same cycle; the lookup returns pre-update contents.
REQ-021 SHALL ignore updates while upd_en=0, so a stalled MEM stage updates the table exactly once.
REQ-022 SHALL perform all PC+4 arithmetic modulo 2^32 (wrap at 0xFFFFFFFC gives 0x00000000).

Reset
REQ-023 SHALL, on RST=1, immediately clear every valid bit and set every counter to WNT.
- pred_taken SHALL then read 0 and pred_target SHALL read if_pc+4.
- br_count and mis_count SHALL reset to 0.
REQ-024 SHALL discard any update coinciding with reset, including reset asserted mid-update.

Configuration
REQ-025 SHALL, with BP_STATS_EN defined, implement the performance counters:
- br_count increments on each accepted update.
- mis_count increments on each accepted update with bp_stat=BP_MISPRED.
- Both saturate at 0xFFFFFFFF.
REQ-026 SHALL, without BP_STATS_EN, tie br_count and mis_count to 0 and infer no counter registers.

Structure
REQ-027 SHALL declare branch_pred_state_t (BP_NONE, BP_CORRECT, BP_MISPRED) and the 2-bit counter enum in dp_types_pkg.
REQ-028 SHALL implement the saturating 2-bit counter update as sub-module sat_counter2 (inputs cnt, taken; output next cnt).

Verification
REQ-029 SHALL cover these directed scenarios:
- Reset, then if_pc=0x00000040 -> pred_taken=0, pred_target=0x00000044.
- Taken update at mem_pc=0x40, mem_target=0x100, then if_pc=0x40 -> pred_taken=1, pred_target=0x100, counter=WT.
- Two not-taken updates at 0x40 -> counter WT->WNT->SNT, pred_taken=0; a third not-taken stays SNT.
- Aliasing: entry at 0x40, then lookup at 0x80 (same idx for 16 entries, different tag) -> pred_taken=0.
- mem_branch=1, mem_pred_taken=0, mem_taken=1, mem_target=0x200 -> bp_stat=BP_MISPRED, fix_pc=0x200; with BP_STATS_EN, mis_count=1 after the edge.
- upd_en=0 held 3 cycles with a valid taken branch, then 1 for one cycle -> exactly one counter step.
